axis_hdr_arbiter: RTL
=====================

AXIS_HDR_ARBITER -- requirements
Module: axis_hdr_arbiter

Interface
REQ-001 Parameter DATA_WD, default 32, data width in bits.
REQ-002 Parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat.
REQ-003 Parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), byte-count width.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_hdr_valid / s_hdr_ready  input / output  2 / 2  per-source header handshake; bit n = source n.
REQ-007 s_hdr_data / s_hdr_keep / s_hdr_cnt  input  2*DATA_WD / 2*DATA_BYTE_WD / 2*BYTE_CNT_WD  per-source header fields; source n in slice n.
REQ-008 s_valid / s_last / s_ready  input / input / output  2 / 2 / 2  per-source payload handshake.
REQ-009 s_data / s_keep  input  2*DATA_WD / 2*DATA_BYTE_WD  per-source payload; source n in slice n.
REQ-010 m_hdr_valid, m_hdr_data, m_hdr_keep, m_hdr_cnt  output  1, DATA_WD, DATA_BYTE_WD, BYTE_CNT_WD  header to the header inserter.
REQ-011 m_hdr_ready  input  1  header-inserter header ready.
REQ-012 m_valid, m_data, m_keep, m_last  output  1, DATA_WD, DATA_BYTE_WD, 1  payload to the header inserter.
REQ-013 m_ready  input  1  header-inserter payload ready.
REQ-014 grant  output  2  one-hot owner of the path; 0 in IDLE.
REQ-015 pkt_cnt  output  32  {src1[15:0], src0[15:0]} completed-packet counters.

Function
REQ-016 FSM states SHALL be IDLE, HDR, PAY; arbitration is per packet (header plus payload through last).
REQ-017 IDLE: if any s_hdr_valid bit is set, SHALL register winner into grant, go to HDR next cycle; else stay.
REQ-018 Round robin: both requesting -> winner is the source not equal to last_src; single requester wins unconditionally.
REQ-019 Grant decision latency SHALL be exactly 1 cycle (request sampled in IDLE, m_hdr_valid earliest next cycle).
REQ-020 HDR: m_hdr_* SHALL equal granted source header fields combinationally; s_hdr_ready[g] = m_hdr_ready; m_valid = 0.
REQ-021 HDR -> PAY on m_hdr_valid && m_hdr_ready.
REQ-022 PAY: m_valid/m_data/m_keep/m_last SHALL equal granted source payload; s_ready[g] = m_ready; m_hdr_valid = 0.
REQ-023 PAY -> IDLE on m_valid && m_ready && m_last; same edge: last_src <= g, pkt_cnt[g] += 1 (16-bit wrap, 0xFFFF -> 0x0000), grant <= 0.
REQ-024 Non-granted source ready bits, and all ready bits in IDLE, SHALL be 0; its payload is stalled even if presented before its header.
REQ-025 Unrouted outputs SHALL be driven 0 (valid, data, keep, last, cnt).
REQ-026 Granted s_hdr_valid dropping in HDR (protocol violation) SHALL not release grant; m_hdr_valid follows it, FSM waits.
REQ-027 Single-beat packet (s_last on first beat) SHALL complete PAY in one accepted beat.
REQ-028 Back-to-back: request pending at PAY->IDLE SHALL be granted after one IDLE cycle (1-cycle bubble).
REQ-029 m_* outputs SHALL remain stable while valid and ready low (pure pass-through of a stable source).

Reset
REQ-030 rst_n low SHALL force state IDLE, grant = 0, last_src = 1 (source 0 wins first tie), pkt_cnt = 0, all valid/ready outputs 0.
REQ-031 Reset mid-packet SHALL abandon the packet with no counter update; first post-reset arbitration follows REQ-030.

Verification
REQ-032 Source 0 only: header 0xAABBCCDD, keep 0xF, 3-beat payload -> grant 01 one cycle after request, header then 3 beats forwarded, pkt_cnt = 0x0000_0001.
REQ-033 Both request continuously, 4 packets each -> grants alternate 0,1,0,1,...; pkt_cnt = 0x0004_0004.
REQ-034 Source 1 payload valid with no header while source 0 owns path -> s_ready[1] = 0 throughout; source 1 data never on m_data.
REQ-035 Random m_ready/m_hdr_ready 50% stall -> data/keep/last order and values identical to reference model; no beat lost or duplicated.
REQ-036 Reset asserted during PAY beat 2 -> outputs 0 asynchronously; after release, both requesting -> source 0 granted; pkt_cnt = 0.
REQ-037 Preload 0xFFFF packets on source 0, complete one more -> pkt_cnt[15:0] = 0x0000, source 1 field unchanged.

Source files
------------

// File: rtl/axis_hdr_arbiter.sv
// Two-source, packet-granular round-robin arbiter in front of a header inserter.
// Each grant covers one header beat followed by payload beats up to and including last.
module axis_hdr_arbiter #(
  parameter int          DATA_WD       = 32,
  parameter int          DATA_BYTE_WD  = DATA_WD / 8,
  parameter int          BYTE_CNT_WD   = $clog2(DATA_BYTE_WD),
  parameter logic [15:0] PKT_CNT0_INIT = 16'h0000,
  parameter logic [15:0] PKT_CNT1_INIT = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic [1:0]                s_hdr_valid,
  output logic [1:0]                s_hdr_ready,
  input  logic [2*DATA_WD-1:0]      s_hdr_data,
  input  logic [2*DATA_BYTE_WD-1:0] s_hdr_keep,
  input  logic [2*BYTE_CNT_WD-1:0]  s_hdr_cnt,

  input  logic [1:0]                s_valid,
  input  logic [1:0]                s_last,
  output logic [1:0]                s_ready,
  input  logic [2*DATA_WD-1:0]      s_data,
  input  logic [2*DATA_BYTE_WD-1:0] s_keep,

  output logic                      m_hdr_valid,
  output logic [DATA_WD-1:0]        m_hdr_data,
  output logic [DATA_BYTE_WD-1:0]   m_hdr_keep,
  output logic [BYTE_CNT_WD-1:0]    m_hdr_cnt,
  input  logic                      m_hdr_ready,

  output logic                      m_valid,
  output logic [DATA_WD-1:0]        m_data,
  output logic [DATA_BYTE_WD-1:0]   m_keep,
  output logic                      m_last,
  input  logic                      m_ready,

  output logic [1:0]                grant,
  output logic [31:0]               pkt_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_src_q, last_src_d;
  logic       pkt_done;
  logic       sel;
  logic       win1;

  logic [DATA_WD-1:0]      hdr_data_src [2];
  logic [DATA_BYTE_WD-1:0] hdr_keep_src [2];
  logic [BYTE_CNT_WD-1:0]  hdr_cnt_src  [2];
  logic [DATA_WD-1:0]      pay_data_src [2];
  logic [DATA_BYTE_WD-1:0] pay_keep_src [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_split
    assign hdr_data_src[gi] = s_hdr_data[gi*DATA_WD      +: DATA_WD];
    assign hdr_keep_src[gi] = s_hdr_keep[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign hdr_cnt_src[gi]  = s_hdr_cnt [gi*BYTE_CNT_WD  +: BYTE_CNT_WD];
    assign pay_data_src[gi] = s_data    [gi*DATA_WD      +: DATA_WD];
    assign pay_keep_src[gi] = s_keep    [gi*DATA_BYTE_WD +: DATA_BYTE_WD];
  end

  // grant is one-hot outside IDLE, so its upper bit names the owner
  assign sel   = grant_q[1];
  assign grant = grant_q;
  assign win1  = (&s_hdr_valid) ? ~last_src_q : s_hdr_valid[1];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_src_d  = last_src_q;
    pkt_done    = 1'b0;
    s_hdr_ready = '0;
    s_ready     = '0;
    m_hdr_valid = 1'b0;
    m_hdr_data  = '0;
    m_hdr_keep  = '0;
    m_hdr_cnt   = '0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_keep      = '0;
    m_last      = 1'b0;

    case (state_q)
      IDLE: begin
        if (|s_hdr_valid) begin
          grant_d = win1 ? 2'b10 : 2'b01;
          state_d = HDR;
        end
      end
      HDR: begin
        m_hdr_valid      = s_hdr_valid[sel];
        m_hdr_data       = hdr_data_src[sel];
        m_hdr_keep       = hdr_keep_src[sel];
        m_hdr_cnt        = hdr_cnt_src[sel];
        s_hdr_ready[sel] = m_hdr_ready;
        if (s_hdr_valid[sel] && m_hdr_ready) begin
          state_d = PAY;
        end
      end
      PAY: begin
        m_valid      = s_valid[sel];
        m_data       = pay_data_src[sel];
        m_keep       = pay_keep_src[sel];
        m_last       = s_last[sel];
        s_ready[sel] = m_ready;
        if (s_valid[sel] && m_ready && s_last[sel]) begin
          state_d    = IDLE;
          grant_d    = 2'b00;
          last_src_d = sel;
          pkt_done   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // last_src resets to 1 so source 0 takes the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      last_src_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_src_q <= last_src_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    localparam logic [15:0] CNT_INIT = (gi == 0) ? PKT_CNT0_INIT : PKT_CNT1_INIT;
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= CNT_INIT;
      end else if (pkt_done && grant_q[gi]) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end

    assign pkt_cnt[gi*16 +: 16] = cnt_q;
  end

endmodule
